// File: rtl/ooo_decode_stage.sv
// Single-cycle decode stage for an out-of-order front end: decodes a group of
// WIDTH instructions, masks lanes younger than the first HALT and counts dispatches.
module ooo_decode_stage #(
    parameter int WIDTH   = 2,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*INSTR_W-1:0] in_instr,
    input  logic [WIDTH-1:0]       in_lane_vld,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_lane_vld,
    output logic [6*WIDTH-1:0]     out_opcode,
    output logic [WIDTH-1:0]       out_writeRd,
    output logic [WIDTH-1:0]       out_RegDest,
    output logic [WIDTH-1:0]       out_isDispatch,
    output logic [WIDTH-1:0]       out_mem_wen,
    output logic [WIDTH-1:0]       out_halt,
    output logic [WIDTH-1:0]       out_illegal,
    output logic                   halted,
    output logic [CNT_W-1:0]       dispatch_cnt
);

    // Flag vector layout: {illegal, halt, mem_wen, isDispatch, RegDest, writeRd}
    function automatic logic [5:0] decode_op(input logic [5:0] op);
        case (op)
            6'h01, 6'h03, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0E:
                decode_op = 6'b000111;
            6'h02, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0D, 6'h0F, 6'h11,
            6'h1B, 6'h1C, 6'h22, 6'h23:
                decode_op = 6'b000110;
            6'h12:
                decode_op = 6'b001100;
            6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1A,
            6'h1D, 6'h20, 6'h21:
                decode_op = 6'b000100;
            6'h31:
                decode_op = 6'b010100;
            6'h00, 6'h30:
                decode_op = 6'b000000;
            default:
                decode_op = 6'b100000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(m[i]);
        end
        return c;
    endfunction

    logic                 accept;
    logic                 handshake;
    logic                 halt_seen_p0;
    logic [5:0]           lane_flags_p0;
    logic [WIDTH-1:0]     dec_lane_vld_p0;
    logic [6*WIDTH-1:0]   dec_opcode_p0;
    logic [WIDTH-1:0]     dec_writeRd_p0;
    logic [WIDTH-1:0]     dec_RegDest_p0;
    logic [WIDTH-1:0]     dec_isDispatch_p0;
    logic [WIDTH-1:0]     dec_mem_wen_p0;
    logic [WIDTH-1:0]     dec_halt_p0;
    logic [WIDTH-1:0]     dec_illegal_p0;

    // Operand fields are not used by this stage.
    logic unused_operands;
    assign unused_operands = ^in_instr;

    assign in_ready  = !halted && !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    // Stage p0: combinational decode; lanes younger than the first valid HALT are dropped
    always_comb begin
        halt_seen_p0      = 1'b0;
        lane_flags_p0     = '0;
        dec_lane_vld_p0   = '0;
        dec_opcode_p0     = '0;
        dec_writeRd_p0    = '0;
        dec_RegDest_p0    = '0;
        dec_isDispatch_p0 = '0;
        dec_mem_wen_p0    = '0;
        dec_halt_p0       = '0;
        dec_illegal_p0    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            dec_opcode_p0[k*6 +: 6] = in_instr[k*INSTR_W + INSTR_W - 6 +: 6];
            lane_flags_p0 = decode_op(in_instr[k*INSTR_W + INSTR_W - 6 +: 6]);
            if (in_lane_vld[k] && !halt_seen_p0) begin
                dec_lane_vld_p0[k]   = 1'b1;
                dec_writeRd_p0[k]    = lane_flags_p0[0];
                dec_RegDest_p0[k]    = lane_flags_p0[1];
                dec_isDispatch_p0[k] = lane_flags_p0[2];
                dec_mem_wen_p0[k]    = lane_flags_p0[3];
                dec_halt_p0[k]       = lane_flags_p0[4];
                dec_illegal_p0[k]    = lane_flags_p0[5];
                if (lane_flags_p0[4]) begin
                    halt_seen_p0 = 1'b1;
                end
            end
        end
    end

    // Stage p1: output holding register, halt latch and dispatch counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            halted         <= 1'b0;
            dispatch_cnt   <= '0;
            out_lane_vld   <= '0;
            out_opcode     <= '0;
            out_writeRd    <= '0;
            out_RegDest    <= '0;
            out_isDispatch <= '0;
            out_mem_wen    <= '0;
            out_halt       <= '0;
            out_illegal    <= '0;
        end else begin
            if (handshake) begin
                dispatch_cnt <= dispatch_cnt + popcount(out_lane_vld & out_isDispatch);
            end
            if (flush) begin
                out_valid <= 1'b0;
                halted    <= 1'b0;
            end else if (accept) begin
                out_valid      <= 1'b1;
                halted         <= halt_seen_p0;
                out_lane_vld   <= dec_lane_vld_p0;
                out_opcode     <= dec_opcode_p0;
                out_writeRd    <= dec_writeRd_p0;
                out_RegDest    <= dec_RegDest_p0;
                out_isDispatch <= dec_isDispatch_p0;
                out_mem_wen    <= dec_mem_wen_p0;
                out_halt       <= dec_halt_p0;
                out_illegal    <= dec_illegal_p0;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ooo_decode_stage.sv
// Bench for ooo_decode_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the decode stage.
module tb_ooo_decode_stage;

    localparam int WIDTH   = 2;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*INSTR_W-1:0] in_instr;
    logic [WIDTH-1:0]         in_lane_vld;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_lane_vld;
    logic [6*WIDTH-1:0]       out_opcode;
    logic [WIDTH-1:0]         out_writeRd;
    logic [WIDTH-1:0]         out_RegDest;
    logic [WIDTH-1:0]         out_isDispatch;
    logic [WIDTH-1:0]         out_mem_wen;
    logic [WIDTH-1:0]         out_halt;
    logic [WIDTH-1:0]         out_illegal;
    logic                     halted;
    logic [CNT_W-1:0]         dispatch_cnt;

    ooo_decode_stage #(.WIDTH(WIDTH), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_lane_vld(in_lane_vld),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_vld(out_lane_vld), .out_opcode(out_opcode),
        .out_writeRd(out_writeRd), .out_RegDest(out_RegDest),
        .out_isDispatch(out_isDispatch), .out_mem_wen(out_mem_wen),
        .out_halt(out_halt), .out_illegal(out_illegal),
        .halted(halted), .dispatch_cnt(dispatch_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: the group the stage is holding, the halt latch, the counter.
    logic             m_valid;
    logic             m_halted;
    logic [CNT_W-1:0] m_cnt;
    logic [WIDTH-1:0] m_lv;
    logic [5:0]       m_f  [WIDTH];
    logic [5:0]       m_op [WIDTH];

    // Flag vector {illegal, halt, mem_wen, isDispatch, RegDest, writeRd} from the decode table.
    function automatic logic [5:0] ref_flags(input logic [5:0] op);
        bit wr, rd, dp, mw, ht, lg;
        wr = op inside {6'h01, 6'h03, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0E};
        rd = wr || (op inside {6'h02, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0D, 6'h0F,
                               6'h11, 6'h1B, 6'h1C, 6'h22, 6'h23});
        mw = (op == 6'h12);
        ht = (op == 6'h31);
        dp = rd || mw || ht || (op >= 6'h13 && op <= 6'h1A) ||
             (op inside {6'h1D, 6'h20, 6'h21});
        lg = dp || op == 6'h00 || op == 6'h30;
        if (!lg) return 6'b100000;
        return {1'b0, ht, mw, dp, rd, wr};
    endfunction

    function automatic logic [5:0] lane_op(input int k);
        return in_instr[k*INSTR_W + INSTR_W - 6 +: 6];
    endfunction

    function automatic logic [WIDTH-1:0] fvec(input int j);
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH; k++) v[k] = m_f[k][j];
        return v;
    endfunction

    function automatic logic exp_rdy();
        return !m_halted && !flush && (!m_valid || out_ready);
    endfunction

    function automatic logic [INSTR_W-1:0] mk(input logic [5:0] op);
        logic [25:0] rest;
        rest = 26'($urandom);
        return {op, rest};
    endfunction

    function automatic logic [5:0] rop();
        case ($urandom_range(0, 9))
            0: return 6'h01;
            1: return 6'h12;
            2: return 6'h31;
            3: return 6'h00;
            4: return 6'h30;
            5: return 6'h3F;
            6: return 6'h02;
            7: return 6'h13;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_halted = 1'b0;
        m_cnt = '0;
        m_lv = '0;
        for (int k = 0; k < WIDTH; k++) begin
            m_f[k] = '0;
            m_op[k] = '0;
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, m_valid);
        chk("halted", halted, m_halted);
        chk("dispatch_cnt", dispatch_cnt, m_cnt);
        chk("in_ready", in_ready, exp_rdy());
        if (m_valid) begin
            chk("lane_vld", out_lane_vld, m_lv);
            chk("writeRd", out_writeRd, fvec(0));
            chk("RegDest", out_RegDest, fvec(1));
            chk("isDispatch", out_isDispatch, fvec(2));
            chk("mem_wen", out_mem_wen, fvec(3));
            chk("halt", out_halt, fvec(4));
            chk("illegal", out_illegal, fvec(5));
            for (int k = 0; k < WIDTH; k++)
                if (m_lv[k]) chk("opcode", out_opcode[k*6 +: 6], m_op[k]);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        logic             nv, nh;
        logic [CNT_W-1:0] nc;
        logic [WIDTH-1:0] nlv;
        logic [5:0]       nf [WIDTH];
        logic [5:0]       nop [WIDTH];
        logic [5:0]       fl;
        int               first_halt, ndisp;
        #1;
        check_all();
        nv = m_valid; nh = m_halted; nc = m_cnt; nlv = m_lv;
        for (int k = 0; k < WIDTH; k++) begin
            nf[k] = m_f[k];
            nop[k] = m_op[k];
        end
        if (m_valid && out_ready) begin
            ndisp = 0;
            for (int k = 0; k < WIDTH; k++) if (m_lv[k] && m_f[k][2]) ndisp++;
            nc = m_cnt + CNT_W'(ndisp);
        end
        if (flush) begin
            nv = 1'b0;
            nh = 1'b0;
        end else if (in_valid && exp_rdy()) begin
            first_halt = WIDTH;
            for (int k = WIDTH - 1; k >= 0; k--) begin
                fl = ref_flags(lane_op(k));
                if (in_lane_vld[k] && fl[4]) first_halt = k;
            end
            for (int k = 0; k < WIDTH; k++) begin
                nop[k] = lane_op(k);
                nlv[k] = in_lane_vld[k] && (k <= first_halt);
                nf[k]  = nlv[k] ? ref_flags(lane_op(k)) : 6'b0;
            end
            nv = 1'b1;
            nh = (first_halt < WIDTH);
        end else if (m_valid && out_ready) begin
            nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_halted = nh; m_cnt = nc; m_lv = nlv;
        for (int k = 0; k < WIDTH; k++) begin
            m_f[k] = nf[k];
            m_op[k] = nop[k];
        end
    endtask

    task automatic set_group(input logic [5:0] op0, input logic [5:0] op1, input logic [1:0] mask);
        in_instr = {mk(op1), mk(op0)};
        in_lane_vld = mask;
        in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CNT_W-1:0] c0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_lane_vld = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cnt", dispatch_cnt, '0);
        chk("rst_flags", {out_lane_vld, out_writeRd, out_RegDest, out_isDispatch,
                          out_mem_wen, out_halt, out_illegal}, '0);
        chk("rst_opcode", out_opcode, '0);
        rst = 1'b0;
        tick();

        // ADD + SW
        set_group(6'h01, 6'h12, 2'b11);
        tick();
        in_valid = 1'b0;
        chk("add_sw_wr", out_writeRd, 2'b01);
        chk("add_sw_rd", out_RegDest, 2'b01);
        chk("add_sw_mw", out_mem_wen, 2'b10);
        chk("add_sw_dp", out_isDispatch, 2'b11);
        tick();
        chk("add_sw_cnt", dispatch_cnt, 4'd2);

        // Backpressure: held group stable, then taken exactly once
        set_group(6'h06, 6'h12, 2'b11);
        tick();
        out_ready = 1'b0;
        set_group(6'h01, 6'h01, 2'b11);
        c0 = m_cnt;
        repeat (3) tick();
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_cnt", dispatch_cnt, c0 + 4'd2);

        // HALT in lane 0 masks the younger ADD and blocks input until flush
        set_group(6'h31, 6'h01, 2'b11);
        tick();
        chk("halt_lv", out_lane_vld, 2'b01);
        chk("halt_dp", out_isDispatch, 2'b01);
        chk("halt_latch", halted, 1'b1);
        set_group(6'h01, 6'h01, 2'b11);
        repeat (3) tick();
        chk("halt_hold", halted, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_unhalt", halted, 1'b0);
        tick();

        // Illegal opcode and NOP
        set_group(6'h3F, 6'h00, 2'b11);
        tick();
        in_valid = 1'b0;
        c0 = m_cnt;
        chk("illegal_flag", out_illegal, 2'b01);
        chk("illegal_dp", out_isDispatch, 2'b00);
        tick();
        chk("illegal_cnt", dispatch_cnt, c0);

        // Counter wrap
        for (int i = 0; i < 20 && m_cnt != 4'hF; i++) begin
            set_group(6'h01, 6'h00, 2'b01);
            tick();
            in_valid = 1'b0;
            tick();
        end
        chk("wrap_pre", dispatch_cnt, 4'hF);
        set_group(6'h01, 6'h12, 2'b11);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_post", dispatch_cnt, 4'd1);

        // Flush in the same cycle as an output handshake
        set_group(6'h01, 6'h12, 2'b11);
        tick();
        c0 = m_cnt;
        flush = 1'b1;
        set_group(6'h02, 6'h02, 2'b11);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_hs_cnt", dispatch_cnt, c0 + 4'd2);
        chk("flush_hs_vld", out_valid, 1'b0);
        tick();

        // Asynchronous reset pulse between edges while a group is held
        set_group(6'h01, 6'h02, 2'b11);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", out_valid, 1'b0);
        chk("arst_cnt", dispatch_cnt, '0);
        model_reset();
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Random traffic
        repeat (400) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            in_lane_vld = 2'($urandom);
            in_instr    = {mk(rop()), mk(rop())};
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
